i2c_txn_sequencer: RTL and testbench

//  Register-level transaction sequencer in front of the byte-level I2C controller.
//  It accepts one register write or register read request and sequences the controller's command interface (start/wr/rd/restart/stop).
//  It checks ACK, captures read data, guards every step with a timeout, and returns one response per request.
//  It sits between the system register bus and the I2C controller (cmd/wr_i2c/ready/done_tick).

---
 rtl/i2c_txn_sequencer_if.sv | 34 +++
 rtl/i2c_txn_sequencer.sv | 140 ++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_sequencer_if.sv
// rtl/i2c_txn_sequencer_if.sv - request/response and I2C controller command bundle for the sequencer
interface i2c_txn_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  logic       i2c_wr;
  logic [2:0] i2c_cmd;
  logic [7:0] i2c_din;
  logic       i2c_ready;
  logic       i2c_done_tick;
  logic       i2c_ack;
  logic [7:0] i2c_dout;

  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  i2c_ready, i2c_done_tick, i2c_ack, i2c_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output i2c_wr, i2c_cmd, i2c_din
  );

  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output i2c_ready, i2c_done_tick, i2c_ack, i2c_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  i2c_wr, i2c_cmd, i2c_din
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// rtl/i2c_txn_sequencer.sv - register write/read sequencer driving the byte-level I2C controller
module i2c_txn_sequencer #(
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  i2c_txn_sequencer_if.slave bus
);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_CPL, RESP} state_t;

  state_t          state;
  logic [2:0]      step;
  logic            rw;
  logic [6:0]      dev;
  logic [7:0]      reg_addr;
  logic [7:0]      wdata;
  logic            aborting;
  logic [TO_W-1:0] to_cnt;

  // {cmd, din} for a step; writes end with STOP at step 4, reads at step 6
  function automatic logic [10:0] step_op(input logic [2:0] s, input logic r,
                                          input logic [6:0] d, input logic [7:0] ra,
                                          input logic [7:0] wd);
    case (s)
      3'd0:    return {CMD_START, 8'h00};
      3'd1:    return {CMD_WR, d, 1'b0};
      3'd2:    return {CMD_WR, ra};
      3'd3:    return r ? {CMD_RESTART, 8'h00} : {CMD_WR, wd};
      3'd4:    return r ? {CMD_WR, d, 1'b1} : {CMD_STOP, 8'h00};
      3'd5:    return {CMD_RD, 8'h00};
      default: return {CMD_STOP, 8'h00};
    endcase
  endfunction

  logic        byte_step;
  logic        step_done;
  logic        timed_out;
  logic [10:0] next_op;

  // The held command register tells which completion event the current step uses
  assign byte_step = (bus.i2c_cmd == CMD_WR) || (bus.i2c_cmd == CMD_RD);
  assign step_done = byte_step ? bus.i2c_done_tick : bus.i2c_ready;
  assign timed_out = (to_cnt >= TO_W'(TIMEOUT));
  assign next_op   = step_op(step + 3'd1, rw, dev, reg_addr, wdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      step          <= 3'd0;
      rw            <= 1'b0;
      dev           <= 7'd0;
      reg_addr      <= 8'd0;
      wdata         <= 8'd0;
      aborting      <= 1'b0;
      to_cnt        <= '0;
      bus.req_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'd0;
      bus.rsp_err   <= 2'b00;
      bus.i2c_wr    <= 1'b0;
      bus.i2c_cmd   <= CMD_STOP;
      bus.i2c_din   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            rw            <= bus.req_rw;
            dev           <= bus.req_dev;
            reg_addr      <= bus.req_reg;
            wdata         <= bus.req_wdata;
            step          <= 3'd0;
            aborting      <= 1'b0;
            bus.busy      <= 1'b1;
            bus.req_ready <= 1'b0;
            bus.rsp_err   <= 2'b00;
            bus.rsp_rdata <= 8'd0;
            bus.i2c_wr    <= 1'b1;
            bus.i2c_cmd   <= CMD_START;
            bus.i2c_din   <= 8'd0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.i2c_wr <= 1'b0;
          to_cnt     <= '0;
          state      <= WAIT_LO;
        end
        WAIT_LO, WAIT_CPL: begin
          to_cnt <= to_cnt + 1'b1;
          if (state == WAIT_LO && !bus.i2c_ready) begin
            state <= WAIT_CPL;
          end else if (state == WAIT_CPL && step_done) begin
            if (bus.i2c_cmd == CMD_RD) bus.rsp_rdata <= bus.i2c_dout;
            if (bus.i2c_cmd == CMD_WR && bus.i2c_ack) begin
              bus.rsp_err <= 2'b01;
              aborting    <= 1'b1;
              bus.i2c_wr  <= 1'b1;
              bus.i2c_cmd <= CMD_STOP;
              bus.i2c_din <= 8'd0;
              state       <= ISSUE;
            end else if (bus.i2c_cmd == CMD_STOP) begin
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              step        <= step + 3'd1;
              bus.i2c_wr  <= 1'b1;
              bus.i2c_cmd <= next_op[10:8];
              bus.i2c_din <= next_op[7:0];
              state       <= ISSUE;
            end
          end else if (timed_out) begin
            // Bus considered hung: report without issuing a stop; a NACK already reported wins
            if (!aborting) bus.rsp_err <= 2'b10;
            bus.rsp_rdata <= 8'd0;
            bus.i2c_cmd   <= CMD_STOP;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb/tb_i2c_txn_sequencer.sv - scoreboard bench for i2c_txn_sequencer with a behavioural controller model
module tb_i2c_txn_sequencer;

  localparam logic [2:0] C_START   = 3'd0;
  localparam logic [2:0] C_WR      = 3'd1;
  localparam logic [2:0] C_RD      = 3'd2;
  localparam logic [2:0] C_STOP    = 3'd3;
  localparam logic [2:0] C_RESTART = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  i2c_txn_sequencer_if bus();

  i2c_txn_sequencer #(.TIMEOUT(100), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [10:0] exp_s[$];
  logic [10:0] obs_s[$];
  int          obs_c[$];
  logic [9:0]  exp_r[$];
  logic [9:0]  obs_r[$];
  int          obs_rc[$];

  logic        hang = 1'b0;
  logic        nack_en = 1'b0;
  logic [7:0]  nack_byte = 8'h00;
  logic        stall_en = 1'b0;
  logic [7:0]  stall_byte = 8'h00;
  logic [7:0]  rd_byte = 8'h00;
  logic [10:0] m_op;
  logic        m_active;
  int          m_cnt;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Controller model: drops ready after a strobe, completes two cycles later
  initial begin
    bus.i2c_ready = 1'b1; bus.i2c_done_tick = 1'b0; bus.i2c_ack = 1'b0; bus.i2c_dout = 8'h00;
    m_active = 1'b0; m_cnt = 0; m_op = '0;
    forever begin
      @(negedge clk);
      bus.i2c_done_tick = 1'b0;
      if (!rst) begin
        bus.i2c_ready = 1'b1;
        m_active = 1'b0;
      end else if (bus.i2c_wr) begin
        obs_s.push_back({bus.i2c_cmd, bus.i2c_din});
        obs_c.push_back(cyc);
        m_op = {bus.i2c_cmd, bus.i2c_din};
        m_active = 1'b1;
        m_cnt = 0;
        if (!hang) bus.i2c_ready = 1'b0;
      end else if (m_active && !hang && !(stall_en && m_op == {C_WR, stall_byte})) begin
        m_cnt++;
        if (m_cnt == 2) begin
          bus.i2c_ready = 1'b1;
          m_active = 1'b0;
          if (m_op[10:8] == C_WR || m_op[10:8] == C_RD) begin
            bus.i2c_done_tick = 1'b1;
            bus.i2c_ack  = nack_en && (m_op == {C_WR, nack_byte});
            bus.i2c_dout = (m_op[10:8] == C_RD) ? rd_byte : 8'hEE;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst && bus.rsp_valid) begin
      obs_r.push_back({bus.rsp_err, bus.rsp_rdata});
      obs_rc.push_back(cyc);
    end
  end

  task automatic clear_q();
    exp_s.delete(); obs_s.delete(); obs_c.delete();
    exp_r.delete(); obs_r.delete(); obs_rc.delete();
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    int to;
    @(negedge clk);
    bus.req_rw = rw; bus.req_dev = dev; bus.req_reg = ra; bus.req_wdata = wd; bus.req_valid = 1'b1;
    to = 0;
    while (!bus.req_ready && to < 1000) begin @(negedge clk); to++; end
    if (to >= 1000) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout req_ready got %0b required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int to;
    to = 0;
    while (obs_r.size() < n && to < 2000) begin @(negedge clk); to++; end
    if (to >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout responses got %0d required %0d", obs_r.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b required 1", bus.req_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", bus.busy); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b required 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata got %h required 00", bus.rsp_rdata); end
    n_tests++; if (bus.rsp_err !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_err got %b required 00", bus.rsp_err); end
    n_tests++; if (bus.i2c_wr !== 1'b0) begin n_fail++; $display("FAIL reset_i2c_wr got %b required 0", bus.i2c_wr); end
    n_tests++; if (bus.i2c_cmd !== C_STOP) begin n_fail++; $display("FAIL reset_i2c_cmd got %b required 011", bus.i2c_cmd); end
    n_tests++; if (bus.i2c_din !== 8'h00) begin n_fail++; $display("FAIL reset_i2c_din got %h required 00", bus.i2c_din); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1 || bus.i2c_wr !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset ready/wr got %b%b required 10", bus.req_ready, bus.i2c_wr);
    end
  endtask

  task automatic test_write();
    logic [10:0] o;
    logic [9:0]  e, g;
    clear_q();
    exp_s = '{{C_START, 8'h00}, {C_WR, 8'hA0}, {C_WR, 8'h10}, {C_WR, 8'hA5}, {C_STOP, 8'h00}};
    exp_r.push_back({2'b00, 8'h00});
    send_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp(1);
    n_tests++; if (obs_s.size() != exp_s.size()) begin n_fail++; $display("FAIL write_strobe_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size(); i++) begin
      o = (i < obs_s.size()) ? obs_s[i] : 11'h7FF;
      n_tests++;
      if (o[10:8] !== exp_s[i][10:8] || (exp_s[i][10:8] == C_WR && o[7:0] !== exp_s[i][7:0])) begin
        n_fail++; $display("FAIL write_strobe%0d got %h required %h", i, o, exp_s[i]);
      end
    end
    e = exp_r.pop_front();
    g = (obs_r.size() > 0) ? obs_r.pop_front() : 10'h3FF;
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL write_rsp err/rdata got %h required %h", g, e); end
    n_tests++; if (obs_c.size() > 1 && obs_c[1] - obs_c[0] < 3) begin
      n_fail++; $display("FAIL write_strobe_gap got %0d required >=3", obs_c[1] - obs_c[0]);
    end
  endtask

  task automatic test_read();
    logic [10:0] o;
    logic [9:0]  e, g;
    clear_q();
    rd_byte = 8'h3C;
    exp_s = '{{C_START, 8'h00}, {C_WR, 8'hA0}, {C_WR, 8'h22}, {C_RESTART, 8'h00},
              {C_WR, 8'hA1}, {C_RD, 8'h00}, {C_STOP, 8'h00}};
    exp_r.push_back({2'b00, 8'h3C});
    send_req(1'b1, 7'h50, 8'h22, 8'h99);
    wait_rsp(1);
    n_tests++; if (obs_s.size() != exp_s.size()) begin n_fail++; $display("FAIL read_strobe_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size(); i++) begin
      o = (i < obs_s.size()) ? obs_s[i] : 11'h7FF;
      n_tests++;
      if (o[10:8] !== exp_s[i][10:8] || (exp_s[i][10:8] == C_WR && o[7:0] !== exp_s[i][7:0])) begin
        n_fail++; $display("FAIL read_strobe%0d got %h required %h", i, o, exp_s[i]);
      end
    end
    e = exp_r.pop_front();
    g = (obs_r.size() > 0) ? obs_r.pop_front() : 10'h3FF;
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL read_rsp err/rdata got %h required %h", g, e); end
  endtask

  task automatic test_nack();
    logic [10:0] o;
    logic [9:0]  e, g;
    clear_q();
    nack_en = 1'b1; nack_byte = 8'hA2;
    exp_s = '{{C_START, 8'h00}, {C_WR, 8'hA2}, {C_STOP, 8'h00}};
    exp_r.push_back({2'b01, 8'h00});
    send_req(1'b0, 7'h51, 8'h10, 8'h5A);
    wait_rsp(1);
    nack_en = 1'b0;
    n_tests++; if (obs_s.size() != exp_s.size()) begin n_fail++; $display("FAIL nack_strobe_count got %0d required %0d", obs_s.size(), exp_s.size()); end
    for (int i = 0; i < exp_s.size(); i++) begin
      o = (i < obs_s.size()) ? obs_s[i] : 11'h7FF;
      n_tests++;
      if (o[10:8] !== exp_s[i][10:8] || (exp_s[i][10:8] == C_WR && o[7:0] !== exp_s[i][7:0])) begin
        n_fail++; $display("FAIL nack_strobe%0d got %h required %h", i, o, exp_s[i]);
      end
    end
    e = exp_r.pop_front();
    g = (obs_r.size() > 0) ? obs_r.pop_front() : 10'h3FF;
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL nack_rsp err/rdata got %h required %h", g, e); end
  endtask

  task automatic test_timeout();
    logic [9:0] e, g;
    int         dt;
    clear_q();
    hang = 1'b1;
    exp_r.push_back({2'b10, 8'h00});
    send_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp(1);
    hang = 1'b0;
    n_tests++; if (obs_s.size() != 1 || obs_s[0][10:8] !== C_START) begin
      n_fail++; $display("FAIL timeout_strobes got count %0d required 1 start", obs_s.size());
    end
    e = exp_r.pop_front();
    g = (obs_r.size() > 0) ? obs_r.pop_front() : 10'h3FF;
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL timeout_rsp err/rdata got %h required %h", g, e); end
    n_tests++; if (bus.i2c_cmd !== C_STOP) begin n_fail++; $display("FAIL timeout_i2c_cmd got %b required 011", bus.i2c_cmd); end
    dt = (obs_c.size() > 0 && obs_rc.size() > 0) ? obs_rc[0] - obs_c[0] : -1;
    n_tests++; if (dt < 101 || dt > 103) begin n_fail++; $display("FAIL timeout_latency got %0d required 101..103", dt); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, g;
    int         to, dt;
    clear_q();
    exp_r.push_back({2'b00, 8'h00});
    exp_r.push_back({2'b00, 8'h00});
    @(negedge clk);
    bus.req_rw = 1'b0; bus.req_dev = 7'h50; bus.req_reg = 8'h01; bus.req_wdata = 8'h11; bus.req_valid = 1'b1;
    to = 0;
    while (!bus.req_ready && to < 1000) begin @(negedge clk); to++; end
    @(negedge clk);
    bus.req_reg = 8'h02; bus.req_wdata = 8'h22;
    to = 0;
    while (!bus.req_ready && to < 1000) begin @(negedge clk); to++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_tests++; if (to >= 1000) begin n_fail++; $display("FAIL b2b_accept got timeout required accept"); end
    wait_rsp(2);
    repeat (40) @(negedge clk);
    n_tests++; if (obs_r.size() != 2) begin n_fail++; $display("FAIL b2b_rsp_count got %0d required 2", obs_r.size()); end
    n_tests++; if (obs_s.size() != 10) begin n_fail++; $display("FAIL b2b_strobe_count got %0d required 10", obs_s.size()); end
    n_tests++; if (obs_s.size() > 8 && obs_s[8] !== {C_WR, 8'h22}) begin
      n_fail++; $display("FAIL b2b_second_data got %h required %h", obs_s[8], {C_WR, 8'h22});
    end
    dt = (obs_c.size() > 5 && obs_rc.size() > 0) ? obs_c[5] - obs_rc[0] : -1;
    n_tests++; if (dt < 1 || dt > 2) begin n_fail++; $display("FAIL b2b_restart_gap got %0d required 1..2", dt); end
    for (int i = 0; i < 2; i++) begin
      e = exp_r.pop_front();
      g = (obs_r.size() > 0) ? obs_r.pop_front() : 10'h3FF;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_rsp%0d got %h required %h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    int to;
    clear_q();
    stall_en = 1'b1; stall_byte = 8'h10;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5);
    to = 0;
    while (obs_s.size() < 3 && to < 500) begin @(negedge clk); to++; end
    repeat (5) @(negedge clk);
    n_tests++; if (obs_s.size() != 3 || obs_s[2] !== {C_WR, 8'h10} || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_setup strobes got %0d busy %b required 3 busy 1", obs_s.size(), bus.busy);
    end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.i2c_wr !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async busy/ready/wr got %b%b%b required 010", bus.busy, bus.req_ready, bus.i2c_wr);
    end
    n_tests++; if (bus.i2c_cmd !== C_STOP || bus.i2c_din !== 8'h00 || bus.rsp_err !== 2'b00) begin
      n_fail++; $display("FAIL midrst_cmd cmd/din/err got %b/%h/%b required 011/00/00", bus.i2c_cmd, bus.i2c_din, bus.rsp_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    stall_en = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release ready/busy got %b%b required 10", bus.req_ready, bus.busy);
    end
    repeat (150) @(negedge clk);
    n_tests++; if (obs_r.size() != 0 || obs_s.size() != 3) begin
      n_fail++; $display("FAIL midrst_no_rsp rsp %0d strobes %0d required 0 and 3", obs_r.size(), obs_s.size());
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_dev = 7'h00; bus.req_reg = 8'h00; bus.req_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
